// File: rtl/rs_encoder_stream.sv
// Systematic RS(255,239)-family stream encoder over GF(256) with 16 parity bytes.
// Message beats pass straight through, and one 16-byte parity beat is appended per codeword.
module rs_encoder_stream #(
  parameter int MSG_BEATS = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(MSG_BEATS - 1);

  // GF(256) multiply, field polynomial x^8+x^4+x^3+x^2+1
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1D) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Coefficients g_0..g_15 of prod_{j=0..15}(x + alpha^j); g_16 = 1 is implicit
  function automatic logic [127:0] gen_poly();
    logic [135:0] p;
    logic [7:0]   a;
    p = 136'd1;
    a = 8'h01;
    for (int j = 0; j < 16; j++) begin
      for (int k = 16; k >= 1; k--) begin
        p[8*k +: 8] = p[8*(k-1) +: 8] ^ gf256_mul(p[8*k +: 8], a);
      end
      p[7:0] = gf256_mul(p[7:0], a);
      a = gf256_mul(a, 8'h02);
    end
    return p[127:0];
  endfunction

  localparam logic [127:0] GEN = gen_poly();

  // Sixteen unrolled LFSR steps, lane 0 (highest-degree byte) first
  function automatic logic [127:0] lfsr_beat(input logic [127:0] par_in, input logic [127:0] beat);
    logic [127:0] par;
    logic [7:0]   fb;
    par = par_in;
    for (int i = 0; i < 16; i++) begin
      fb = beat[8*i +: 8] ^ par[127:120];
      for (int k = 15; k >= 1; k--) begin
        par[8*k +: 8] = par[8*(k-1) +: 8] ^ gf256_mul(fb, GEN[8*k +: 8]);
      end
      par[7:0] = gf256_mul(fb, GEN[7:0]);
    end
    return par;
  endfunction

  // Parity register holds par[15] in the top byte; it leaves on lane 0
  function automatic logic [127:0] lane_order(input logic [127:0] par);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = par[8*(15-i) +: 8];
    end
    return r;
  endfunction

  state_t       state_r, state_s;
  logic [3:0]   beat_cnt_r, beat_cnt_s;
  logic [127:0] par_r, par_s;
  logic         in_ready_s, out_valid_s, out_last_s;
  logic [127:0] out_data_s;

  // State, beat counter and parity register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_DATA;
      beat_cnt_r <= 4'd0;
      par_r      <= 128'd0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      par_r      <= par_s;
    end
  end

  // Next-state logic and stream handshakes
  always_comb begin
    state_s     = state_r;
    beat_cnt_s  = beat_cnt_r;
    par_s       = par_r;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    out_data_s  = 128'd0;
    if (clear) begin
      state_s    = ST_DATA;
      beat_cnt_s = 4'd0;
      par_s      = 128'd0;
    end else begin
      case (state_r)
        ST_DATA: begin
          in_ready_s  = out_ready;
          out_valid_s = in_valid;
          out_data_s  = in_data;
          if (in_valid && out_ready) begin
            par_s = lfsr_beat(par_r, in_data);
            if (beat_cnt_r == LAST_BEAT) begin
              beat_cnt_s = 4'd0;
              state_s    = ST_PARITY;
            end else begin
              beat_cnt_s = beat_cnt_r + 4'd1;
            end
          end else begin
            par_s = par_r;
          end
        end
        ST_PARITY: begin
          out_valid_s = 1'b1;
          out_last_s  = 1'b1;
          out_data_s  = lane_order(par_r);
          if (out_ready) begin
            par_s   = 128'd0;
            state_s = ST_DATA;
          end else begin
            state_s = ST_PARITY;
          end
        end
        default: begin
          state_s    = ST_DATA;
          beat_cnt_s = 4'd0;
          par_s      = 128'd0;
        end
      endcase
    end
  end

  // Outputs are forced quiet while reset is held
  assign in_ready  = rst_n & in_ready_s;
  assign out_valid = rst_n & out_valid_s;
  assign out_last  = rst_n & out_last_s;
  assign out_data  = rst_n ? out_data_s : 128'd0;
  assign busy      = (beat_cnt_r != 4'd0) || (state_r == ST_PARITY);

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Directed bench for rs_encoder_stream: pass-through, parity against a long-division model,
// codeword syndromes, backpressure, clear and reset in the middle of a codeword.
module tb_rs_encoder_stream;

  localparam int NB = 14;
  localparam int N  = NB * 16;

  logic         clk = 1'b0;
  logic         rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [127:0] in_data, out_data;

  int errors = 0;
  int checks = 0;

  logic [7:0]   gpoly [0:16];
  logic [7:0]   msg   [0:N-1];
  logic [7:0]   cw    [0:N+15];
  logic [127:0] last_par;

  always #5 clk = ~clk;

  rs_encoder_stream #(.MSG_BEATS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'd0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011D << (i - 8));
    return prod[7:0];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input int b);
    logic [127:0] r;
    for (int l = 0; l < 16; l++) r[8*l +: 8] = msg[16*b + l];
    return r;
  endfunction

  // Remainder of m(x)*x^16 by polynomial long division; lane 0 is the degree-15 term
  function automatic logic [127:0] model_parity();
    logic [7:0]   c [0:N+15];
    logic [7:0]   coef;
    logic [127:0] r;
    for (int i = 0; i < N + 16; i++) c[i] = (i < N) ? msg[i] : 8'h00;
    for (int i = 0; i < N; i++) begin
      coef = c[i];
      for (int k = 0; k <= 16; k++) c[i+k] = c[i+k] ^ gmul(coef, gpoly[16-k]);
    end
    for (int l = 0; l < 16; l++) r[8*l +: 8] = c[N + l];
    return r;
  endfunction

  // Any syndrome nonzero: evaluate captured codeword at alpha^0..alpha^15
  function automatic bit any_syndrome();
    logic [7:0] a, s;
    bit nz;
    nz = 1'b0;
    a  = 8'h01;
    for (int j = 0; j < 16; j++) begin
      s = 8'h00;
      for (int i = 0; i < N + 16; i++) s = gmul(s, a) ^ cw[i];
      if (s != 8'h00) nz = 1'b1;
      a = gmul(a, 8'h02);
    end
    return nz;
  endfunction

  task automatic send_beats(input int n, input bit gap, input string tag);
    for (int b = 0; b < n; b++) begin
      if (gap && b == 3) begin
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; #1;
        check({tag, " gap out_valid"}, 128'(out_valid), 128'd0);
        @(negedge clk); in_valid = 1'b1; out_ready = 1'b0; in_data = pack(b); #1;
        check({tag, " stall in_ready"}, 128'(in_ready), 128'd0);
      end
      @(negedge clk); in_data = pack(b); in_valid = 1'b1; out_ready = 1'b1; #1;
      check({tag, " fwd data"}, out_data, pack(b));
      check({tag, " fwd flags"}, {125'd0, out_valid, in_ready, out_last}, {125'd0, 3'b110});
      for (int l = 0; l < 16; l++) cw[16*b + l] = out_data[8*l +: 8];
    end
  endtask

  task automatic finish_parity(input bit stall, input string tag);
    logic [127:0] exp_par;
    exp_par = model_parity();
    @(negedge clk); in_valid = 1'b1; in_data = {4{32'hDEADBEEF}}; out_ready = !stall; #1;
    check({tag, " parity data"}, out_data, exp_par);
    check({tag, " parity flags"}, {125'd0, out_valid, in_ready, out_last}, {125'd0, 3'b101});
    if (stall) begin
      repeat (3) begin
        @(negedge clk); #1;
        check({tag, " parity held"}, out_data, exp_par);
        check({tag, " stall busy/in_ready"}, {126'd0, busy, in_ready}, {126'd0, 2'b10});
      end
      out_ready = 1'b1; #1;
    end
    last_par = out_data;
    for (int l = 0; l < 16; l++) cw[N + l] = out_data[8*l +: 8];
    @(negedge clk); in_valid = 1'b0; #1;
    check({tag, " after parity"}, {125'd0, busy, out_valid, out_last}, 128'd0);
  endtask

  initial begin
    logic [7:0]   a;
    logic [127:0] exp_g;
    for (int k = 0; k <= 16; k++) gpoly[k] = (k == 0) ? 8'h01 : 8'h00;
    a = 8'h01;
    for (int j = 0; j < 16; j++) begin
      for (int k = 16; k >= 1; k--) gpoly[k] = gpoly[k-1] ^ gmul(gpoly[k], a);
      gpoly[0] = gmul(gpoly[0], a);
      a = gmul(a, 8'h02);
    end

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = '1;
    #12;
    check("reset outputs", {out_data[7:0], 4'd0, in_ready, out_valid, out_last, busy}, 128'd0);
    check("reset data", out_data, 128'd0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0; #1;
    check("post-reset in_ready", 128'(in_ready), 128'd1);

    // 1: all-zero message
    for (int i = 0; i < N; i++) msg[i] = 8'h00;
    send_beats(NB, 1'b0, "zero");
    finish_parity(1'b0, "zero");
    check("zero parity const", last_par, 128'd0);

    // 2: single 0x01 in last byte -> parity equals g_15..g_0
    msg[N-1] = 8'h01;
    send_beats(NB, 1'b0, "unit");
    finish_parity(1'b0, "unit");
    for (int l = 0; l < 16; l++) exp_g[8*l +: 8] = gpoly[15-l];
    check("unit parity=g", last_par, exp_g);
    check("g0=alpha^120", 128'(gpoly[0]), 128'(8'h3B ^ 8'h3B ^ gpoly[0]) & 128'hFF);

    // 3/4: patterned message with gaps and parity stall, then syndromes
    for (int i = 0; i < N; i++) msg[i] = 8'((i * 37 + 11) ^ (i >> 3));
    send_beats(NB, 1'b1, "pat");
    finish_parity(1'b1, "pat");
    check("pat syndromes zero", 128'(any_syndrome()), 128'd0);
    cw[50] = cw[50] ^ 8'h5A;
    check("pat corrupted syndrome", 128'(any_syndrome()), 128'd1);

    // 5: clear after six beats, then a fresh message
    for (int i = 0; i < N; i++) msg[i] = 8'(i * 3 + 200);
    send_beats(6, 1'b0, "pre-clear");
    check("busy mid codeword", 128'(busy), 128'd1);
    @(negedge clk); clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1; #1;
    check("clear cycle", {126'd0, in_ready, out_valid}, 128'd0);
    @(negedge clk); clear = 1'b0; in_valid = 1'b0; #1;
    check("after clear busy", 128'(busy), 128'd0);
    for (int i = 0; i < N; i++) msg[i] = 8'(255 - i) ^ 8'hA5;
    send_beats(NB, 1'b0, "fresh");
    finish_parity(1'b0, "fresh");
    check("fresh syndromes zero", 128'(any_syndrome()), 128'd0);

    // 6: reset while the parity beat is stalled
    send_beats(NB, 1'b0, "rst");
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0; #1;
    check("rst parity pending", {126'd0, out_valid, out_last}, 128'd3);
    rst_n = 1'b0; #1;
    check("rst mid parity", {125'd0, out_valid, busy, out_last}, 128'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N; i++) msg[i] = 8'(i * 91 + 5);
    send_beats(NB, 1'b0, "post-rst");
    finish_parity(1'b0, "post-rst");
    check("post-rst syndromes zero", 128'(any_syndrome()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
